// File: rtl/bram_stream_loader.sv
// Packs a valid/ready element stream into DWIDTH rows, writes them to BRAM0,
// then pulses start_run_o with the row count to kick off the accumulate stage.
module bram_stream_loader #(
  parameter int CNT_BIT       = 31,
  parameter int DWIDTH        = 32,
  parameter int AWIDTH        = 12,
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_load_i,
  input  logic [CNT_BIT-1:0]       load_count_i,
  input  logic                     s_valid_i,
  input  logic [IN_DATA_WIDTH-1:0] s_data_i,
  output logic                     s_ready_o,
  output logic                     idle_o,
  output logic                     load_o,
  output logic                     done_o,
  output logic [AWIDTH-1:0]        addr_b0_o,
  output logic                     ce_b0_o,
  output logic                     we_b0_o,
  output logic [DWIDTH-1:0]        d_b0_o,
  output logic                     start_run_o,
  output logic [CNT_BIT-1:0]       run_count_o
);

  localparam int LANES = DWIDTH / IN_DATA_WIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_BIT-1:0]   count_q;
  logic [CNT_BIT-1:0]   row_idx;
  logic [LW-1:0]        lane;
  logic [DWIDTH-1:0]    pack_q;
  logic [DWIDTH-1:0]    pack_nxt;
  logic                 final_q;
  logic                 xfer;
  logic                 last_lane;
  logic                 last_row;

  function automatic logic [DWIDTH-1:0] insert_lane(
    input logic [DWIDTH-1:0]        row,
    input logic [LW-1:0]            k,
    input logic [IN_DATA_WIDTH-1:0] elem
  );
    logic [DWIDTH-1:0] r;
    r = row;
    for (int i = 0; i < LANES; i++) begin
      if (k == LW'(i)) r[i*IN_DATA_WIDTH +: IN_DATA_WIDTH] = elem;
    end
    return r;
  endfunction

  // Ready depends only on registered state, never on s_valid_i.
  assign s_ready_o = (state == LOAD) && !final_q;
  assign xfer      = s_valid_i && s_ready_o;
  assign last_lane = (lane == LW'(LANES - 1));
  assign last_row  = (row_idx == (count_q - CNT_BIT'(1)));
  assign pack_nxt  = insert_lane(pack_q, lane, s_data_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idle_o      <= 1'b1;
      load_o      <= 1'b0;
      done_o      <= 1'b0;
      count_q     <= '0;
      row_idx     <= '0;
      lane        <= '0;
      pack_q      <= '0;
      final_q     <= 1'b0;
      addr_b0_o   <= '0;
      ce_b0_o     <= 1'b0;
      we_b0_o     <= 1'b0;
      d_b0_o      <= '0;
      start_run_o <= 1'b0;
      run_count_o <= '0;
    end else begin
      ce_b0_o     <= 1'b0;
      we_b0_o     <= 1'b0;
      start_run_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_load_i) begin
            count_q     <= load_count_i;
            run_count_o <= load_count_i;
            row_idx     <= '0;
            lane        <= '0;
            pack_q      <= '0;
            final_q     <= 1'b0;
            idle_o      <= 1'b0;
            if (load_count_i != '0) begin
              state  <= LOAD;
              load_o <= 1'b1;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            if (last_lane) begin
              lane      <= '0;
              pack_q    <= '0;
              addr_b0_o <= row_idx[AWIDTH-1:0];
              d_b0_o    <= pack_nxt;
              ce_b0_o   <= 1'b1;
              we_b0_o   <= 1'b1;
              row_idx   <= row_idx + CNT_BIT'(1);
              if (last_row) final_q <= 1'b1;
            end else begin
              lane   <= lane + LW'(1);
              pack_q <= pack_nxt;
            end
          end
          // final_q is set with the last write, so leaving here lands one cycle after it.
          if (final_q) begin
            state       <= DONE;
            load_o      <= 1'b0;
            done_o      <= 1'b1;
            final_q     <= 1'b0;
            start_run_o <= (count_q != '0);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          idle_o <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          idle_o  <= 1'b1;
          load_o  <= 1'b0;
          done_o  <= 1'b0;
          final_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_loader.sv
// Bench for bram_stream_loader: two instances (AWIDTH 12 and 2) share stimulus;
// a row-queue model predicts every BRAM0 write and its wrapped address.
module tb_bram_stream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_load_i;
  logic [30:0] load_count_i;
  logic        s_valid_i;
  logic [7:0]  s_data_i;

  logic        rdy_a, idle_a, load_a, done_a, ce_a, we_a, sr_a;
  logic [11:0] addr_a;
  logic [31:0] d_a;
  logic [30:0] rc_a;
  logic        rdy_b, idle_b, load_b, done_b, ce_b, we_b, sr_b;
  logic [1:0]  addr_b;
  logic [31:0] d_b;
  logic [30:0] rc_b;

  bram_stream_loader #(.CNT_BIT(31), .DWIDTH(32), .AWIDTH(12), .IN_DATA_WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .start_load_i(start_load_i), .load_count_i(load_count_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(rdy_a),
    .idle_o(idle_a), .load_o(load_a), .done_o(done_a),
    .addr_b0_o(addr_a), .ce_b0_o(ce_a), .we_b0_o(we_a), .d_b0_o(d_a),
    .start_run_o(sr_a), .run_count_o(rc_a)
  );

  bram_stream_loader #(.CNT_BIT(31), .DWIDTH(32), .AWIDTH(2), .IN_DATA_WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .start_load_i(start_load_i), .load_count_i(load_count_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(rdy_b),
    .idle_o(idle_b), .load_o(load_b), .done_o(done_b),
    .addr_b0_o(addr_b), .ce_b0_o(ce_b), .we_b0_o(we_b), .d_b0_o(d_b),
    .start_run_o(sr_b), .run_count_o(rc_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } row_t;

  row_t       exp_q[$];
  logic [7:0] stim[$];
  bit         mon_en = 1'b0;
  row_t       cur;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Row r is made of stream elements 4r..4r+3, first element in the low byte.
  task automatic expect_rows(input int nrows);
    for (int r = 0; r < nrows; r++) begin
      row_t e;
      e.idx  = r;
      e.data = {stim[4*r+3], stim[4*r+2], stim[4*r+1], stim[4*r]};
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot_a", 64'(int'(idle_a) + int'(load_a) + int'(done_a)), 64'd1);
      chk("ce_eq_we_a", ce_a, we_a);
      chk("lockstep_b", {idle_b, load_b, done_b, rdy_b, we_b, ce_b, sr_b},
                        {idle_a, load_a, done_a, rdy_a, we_a, ce_a, sr_a});
      chk("lockstep_rc", rc_b, rc_a);
      if (rdy_a && !load_a) chk("ready_outside_load", rdy_a, 1'b0);
      if (we_a) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1'b1, 1'b0);
        end else begin
          cur = exp_q.pop_front();
          chk("wr_addr_a", addr_a, 64'(cur.idx % 4096));
          chk("wr_addr_b", addr_b, 64'(cur.idx % 4));
          chk("wr_data_a", d_a, cur.data);
          chk("wr_data_b", d_b, cur.data);
        end
      end
    end
  end

  task automatic start_load(input int cnt);
    @(negedge clk);
    start_load_i = 1'b1;
    load_count_i = 31'(cnt);
    @(negedge clk);
    start_load_i = 1'b0;
  endtask

  // Returns at the negedge following the final transfer (cycle M+1).
  task automatic feed(input int gapmax, input int poke_idx);
    int   i;
    int   guard;
    logic r;
    i = 0;
    guard = 0;
    if (poke_idx >= 0) load_count_i = 31'd7;
    while (i < stim.size() && guard < 500) begin
      if (gapmax > 0) begin
        repeat ($urandom_range(gapmax, 0)) begin
          s_valid_i = 1'b0;
          start_load_i = 1'b0;
          @(negedge clk);
          guard++;
        end
      end
      s_valid_i    = 1'b1;
      s_data_i     = stim[i];
      start_load_i = (i == poke_idx);
      r = rdy_a;
      @(negedge clk);
      guard++;
      if (r) i++;
    end
    s_valid_i    = 1'b0;
    start_load_i = 1'b0;
    if (guard >= 500) chk("feed_timeout", 1'b1, 1'b0);
  endtask

  task automatic tail(input int cnt, input bit poke_done);
    chk("wr_at_M1", we_a, 1'b1);
    chk("ready_low_M1", rdy_a, 1'b0);
    chk("load_M1", load_a, 1'b1);
    @(negedge clk);
    chk("done_M2", done_a, 1'b1);
    chk("start_run_M2", sr_a, 1'b1);
    chk("run_count_M2", rc_a, 64'(cnt));
    chk("ready_low_M2", rdy_a, 1'b0);
    chk("no_wr_M2", we_a, 1'b0);
    if (poke_done) begin
      start_load_i = 1'b1;
      load_count_i = 31'd3;
    end
    @(negedge clk);
    start_load_i = 1'b0;
    chk("idle_M3", idle_a, 1'b1);
    chk("load_M3", load_a, 1'b0);
    chk("start_run_M3", sr_a, 1'b0);
    chk("run_count_hold", rc_a, 64'(cnt));
    chk("rows_all_written", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start_load_i = 1'b0;
    load_count_i = '0;
    s_valid_i = 1'b0;
    s_data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_idle", idle_a, 1'b1);
    chk("rst_flags", {load_a, done_a, rdy_a, ce_a, we_a, sr_a}, 6'b0);
    chk("rst_addr_data", {addr_a, d_a}, 44'b0);
    chk("rst_run_count", rc_a, 31'b0);
    mon_en = 1'b1;
    reset = 1'b0;

    // Two rows, continuous valid.
    stim = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    expect_rows(2);
    start_load(2);
    chk("load_after_start", load_a, 1'b1);
    chk("ready_after_start", rdy_a, 1'b1);
    feed(0, -1);
    chk("lit_addr_row1", addr_a, 12'd1);
    chk("lit_data_row1", d_a, 32'h08070605);
    tail(2, 1'b0);

    // Same data with random valid gaps.
    expect_rows(2);
    start_load(2);
    feed(3, -1);
    chk("gap_lit_data_row1", d_a, 32'h08070605);
    tail(2, 1'b0);

    // Zero-row request.
    start_load(0);
    chk("zero_done", done_a, 1'b1);
    chk("zero_no_run", sr_a, 1'b0);
    chk("zero_no_load", load_a, 1'b0);
    @(negedge clk);
    chk("zero_idle", idle_a, 1'b1);
    chk("zero_no_rows", 64'(exp_q.size()), 64'd0);

    // Reset after 6 transfers of a 2-row load.
    stim = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    expect_rows(1);
    start_load(2);
    feed(0, -1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle", idle_a, 1'b1);
    chk("rst_mid_flags", {load_a, done_a, rdy_a, we_a, sr_a}, 5'b0);
    chk("rst_mid_data", d_a, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_wr", we_a, 1'b0);
    chk("rst_mid_rows", 64'(exp_q.size()), 64'd0);
    stim = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    expect_rows(1);
    start_load(1);
    feed(0, -1);
    chk("lit_after_rst_addr", addr_a, 12'd0);
    chk("lit_after_rst_data", d_a, 32'hDDCCBBAA);
    tail(1, 1'b0);

    // Valid held in IDLE is not consumed; start pulses in LOAD and DONE are ignored.
    s_valid_i = 1'b1;
    s_data_i = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_not_ready", rdy_a, 1'b0);
    end
    stim = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    expect_rows(2);
    start_load(2);
    feed(0, 5);
    chk("lit_poke_data", d_a, 32'h80706050);
    tail(2, 1'b1);
    @(negedge clk);
    chk("poke_still_idle", idle_a, 1'b1);

    // Five rows: AWIDTH=2 instance wraps its address back to 0.
    stim.delete();
    for (int k = 0; k < 20; k++) stim.push_back(8'(k * 3 + 1));
    expect_rows(5);
    start_load(5);
    feed(1, -1);
    chk("lit_wrap_addr_b", addr_b, 2'd0);
    chk("lit_wrap_addr_a", addr_a, 12'd4);
    chk("lit_wrap_data", d_b, 32'h3A373431);
    tail(5, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_stream_loader.md
# bram_stream_loader

Upstream feeder for the BRAM accumulate stage. Accepts a valid/ready byte stream and packs four IN_DATA_WIDTH elements per DWIDTH row, LSB lane first. Writes each row into BRAM0 through the standard BRAM memory interface. When the requested row count is stored, it pulses `start_run_o` with `run_count_o`, so the accumulate stage starts without controller intervention.

## Interface
- CNT_BIT, 31, width of row counters and `load_count_i`/`run_count_o`
- DWIDTH, 32, BRAM0 row width
- AWIDTH, 12, BRAM0 address width
- IN_DATA_WIDTH, 8, stream element width; LANES = DWIDTH/IN_DATA_WIDTH (= 4), must divide exactly
- One clock; reset is synchronous and active-high. Ports `clk` and `reset`.
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start_load_i  in  1  start pulse, sampled only in IDLE
- load_count_i  in  CNT_BIT  number of rows to load, latched with `start_load_i`
- s_valid_i  in  1  stream element valid
- s_data_i  in  IN_DATA_WIDTH  stream element
- s_ready_o  out  1  block can accept an element
- idle_o / load_o / done_o  out  1 each  one-hot state outputs
- addr_b0_o  out  AWIDTH  BRAM0 address
- ce_b0_o, we_b0_o  out  1 each  BRAM0 chip/write enable
- d_b0_o  out  DWIDTH  BRAM0 write data
- start_run_o  out  1  one-cycle start pulse to the accumulate stage
- run_count_o  out  CNT_BIT  row count for the accumulate stage; valid while `start_run_o`=1, holds afterwards

## Operation
- FSM states:
  - IDLE -> LOAD on `start_load_i` with `load_count_i` != 0.
  - IDLE -> DONE on `start_load_i` with `load_count_i` == 0.
  - LOAD -> DONE the cycle after the last row write.
  - DONE -> IDLE unconditionally, after one cycle.
- `start_load_i` is ignored outside IDLE.
- Element transfer happens on a rising edge where `s_valid_i` & `s_ready_o` are both 1.
- Packing: the k-th element of a row (k = 0..LANES-1) goes to bits [k*IN_DATA_WIDTH +: IN_DATA_WIDTH]. A lane counter wraps LANES-1 -> 0.
- Row write: the transfer that fills lane LANES-1 causes, in the next cycle, `ce_b0_o`=`we_b0_o`=1, `addr_b0_o` = row index[AWIDTH-1:0], and `d_b0_o` = packed row.
  - The write lasts exactly one cycle.
  - It may coincide with further transfers (no bubble).
- Row index starts at 0, increments per written row, and counts in CNT_BIT bits. The address is its low AWIDTH bits, so it wraps modulo 2^AWIDTH.
- `s_ready_o` = (state == LOAD) & !final. The `final` flag is set on the transfer of the last element of row `load_count`-1, and cleared on leaving LOAD.
- `ce_b0_o` = `we_b0_o` = 0 except on write cycles. The block never reads BRAM0.
- `start_run_o` = 1 during the DONE cycle only, and only if the latched count != 0. `run_count_o` = latched count.
- Reset (any state, any time):
  - All outputs go to 0 except `idle_o` = 1.
  - State returns to IDLE, and counters and the pack register clear.
  - A partial row is discarded, and no write is issued on the cycle after reset.

## Timing
- `start_load_i` at edge N -> `load_o` = 1 and `s_ready_o` = 1 from cycle N+1.
- Throughput: 1 element/cycle, 1 row write per LANES transfers.
- Last transfer at edge M:
  - Cycle M+1: write asserted, `s_ready_o` = 0.
  - Edge M+1: BRAM0 samples the row.
  - Cycle M+2: `done_o` = 1 and `start_run_o` = 1.
  - Cycle M+3: `idle_o` = 1.
- Minimum load (1 row, continuous valid): 4 transfers + 1 write cycle + 1 DONE cycle.
- Outputs are registered except `s_ready_o`, which is decoded from registered state/flag only, with no combinational path from `s_valid_i`.
- Reset values:
  - `idle_o` = 1.
  - `load_o`, `done_o`, `s_ready_o`, `ce_b0_o`, `we_b0_o`, `start_run_o` = 0.
  - `addr_b0_o`, `d_b0_o`, `run_count_o` = 0.

## Test plan
- `load_count_i` = 2, continuous valid with bytes 0x01..0x08:
  - Writes addr 0 = 0x04030201 and addr 1 = 0x08070605.
  - `done_o` and `start_run_o` each high 1 cycle, with `run_count_o` = 2.
  - `s_ready_o` low after the 8th transfer.
- Same data with `s_valid_i` gaps of 0-3 random cycles: identical writes, data order preserved, and no write on a partial row.
- `load_count_i` = 0: IDLE -> DONE -> IDLE with no write and `start_run_o` = 0.
- Reset asserted after 6 transfers of a 2-row load:
  - Next cycle `idle_o` = 1, with no second write.
  - A new load of 1 row with 0xAA,0xBB,0xCC,0xDD writes addr 0 = 0xDDCCBBAA.
- `start_load_i` pulsed during LOAD and DONE is ignored; with `s_valid_i` = 1 while in IDLE, `s_ready_o` stays 0 and nothing is consumed.
- AWIDTH = 2, `load_count_i` = 5: rows are written to addr 0,1,2,3,0 and `run_count_o` = 5.
